// File: rtl/sha_nonce_sweep_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sha_nonce_sweep_ctrl
// Description : Autonomous nonce-sweep sequencer driving a sha256 core's
//               register bus. It hashes an 80-byte header (19 local words plus
//               a swept nonce) as two SHA-256 blocks. Digest word 0 is tested
//               against a leading-zero target, and the sweep stops on a hit or
//               at the end of the nonce range.
//               Optional macro SHA_SWEEP_IRQ_EN adds irq_found / irq_mask.
// Revision    : 1.0 - initial release
// ============================================================================
module sha_nonce_sweep_ctrl #(
  parameter int BITS     = 32,
  parameter int POLL_MAX = 255
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            abort,
  input  logic            hdr_we,
  input  logic [4:0]      hdr_addr,
  input  logic [BITS-1:0] hdr_wdata,
  input  logic [BITS-1:0] nonce_start,
  input  logic [BITS-1:0] nonce_end,
  input  logic [5:0]      target_zeros,
  output logic            busy,
  output logic            done,
  output logic            found,
  output logic            err,
  output logic [BITS-1:0] found_nonce,
  output logic [BITS-1:0] cur_nonce,
  output logic [BITS-1:0] hash_w0,
  output logic            sha_cs,
  output logic            sha_we,
  output logic [7:0]      sha_address,
  output logic [BITS-1:0] sha_write_data,
  input  logic [BITS-1:0] sha_read_data,
  input  logic            sha_error
`ifdef SHA_SWEEP_IRQ_EN
  ,output logic           irq_found
  ,input  logic           irq_mask
`endif
);

  localparam int PW = $clog2(POLL_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_BLK  = 3'd1,
    S_WR_CTRL = 3'd2,
    S_GAP     = 3'd3,
    S_POLL    = 3'd4,
    S_RD_DIG  = 3'd5,
    S_CHECK   = 3'd6
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [BITS-1:0] r_hdr [0:18];
  logic [3:0]      r_word;
  logic            r_blk;
  logic [PW-1:0]   r_poll_cnt;
  logic [BITS-1:0] r_cur_nonce;
  logic [BITS-1:0] r_end_nonce;
  logic [5:0]      r_tz;
  logic [BITS-1:0] r_hash_w0;
  logic [BITS-1:0] r_found_nonce;
  logic            r_found;
  logic            r_err;
  logic            r_done;

  logic            w_cs;
  logic            w_we;
  logic [7:0]      w_addr;
  logic [BITS-1:0] w_wdata;
  logic [BITS-1:0] w_blk_word;
  logic [BITS-1:0] w_mask;
  logic            w_hit_cond;
  logic            w_start_ok;
  logic            w_fin;
  logic            w_err_set;
  logic            w_hit;
  logic            w_nonce_inc;
  logic            w_blk1_go;

  // Leading-zero test: mask covers the top r_tz bits (r_tz already clamped)
  assign w_mask     = ~({BITS{1'b1}} >> r_tz);
  assign w_hit_cond = ((r_hash_w0 & w_mask) == '0);

  // Message word for the current block slot: header words, then nonce and padding
  always_comb begin
    w_blk_word = '0;
    if (!r_blk) begin
      w_blk_word = r_hdr[{1'b0, r_word}];
    end else begin
      case (r_word)
        4'd0:    w_blk_word = r_hdr[16];
        4'd1:    w_blk_word = r_hdr[17];
        4'd2:    w_blk_word = r_hdr[18];
        4'd3:    w_blk_word = r_cur_nonce;
        4'd4:    w_blk_word = 32'h8000_0000;
        4'd15:   w_blk_word = 32'h0000_0280;
        default: w_blk_word = '0;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, bus drive and event strobes; core error then abort override last
  always_comb begin
    w_state_nxt = r_state;
    w_cs        = 1'b0;
    w_we        = 1'b0;
    w_addr      = 8'h00;
    w_wdata     = '0;
    w_start_ok  = 1'b0;
    w_fin       = 1'b0;
    w_err_set   = 1'b0;
    w_hit       = 1'b0;
    w_nonce_inc = 1'b0;
    w_blk1_go   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start_ok  = 1'b1;
          w_state_nxt = S_WR_BLK;
        end
      end
      S_WR_BLK: begin
        w_cs    = 1'b1;
        w_we    = 1'b1;
        w_addr  = {4'h1, r_word};
        w_wdata = w_blk_word;
        if (r_word == 4'd15) w_state_nxt = S_WR_CTRL;
      end
      S_WR_CTRL: begin
        w_cs        = 1'b1;
        w_we        = 1'b1;
        w_addr      = 8'h08;
        w_wdata     = r_blk ? 32'h0000_0006 : 32'h0000_0005;
        w_state_nxt = S_GAP;
      end
      S_GAP: begin
        w_state_nxt = S_POLL;
      end
      S_POLL: begin
        w_cs   = 1'b1;
        w_addr = 8'h09;
        if (sha_read_data[1:0] == 2'b11) begin
          if (r_blk) begin
            w_state_nxt = S_RD_DIG;
          end else begin
            w_blk1_go   = 1'b1;
            w_state_nxt = S_WR_BLK;
          end
        end else if (r_poll_cnt == PW'(POLL_MAX - 1)) begin
          w_err_set   = 1'b1;
          w_fin       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_RD_DIG: begin
        w_cs        = 1'b1;
        w_addr      = 8'h20;
        w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (w_hit_cond) begin
          w_hit       = 1'b1;
          w_fin       = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_cur_nonce == r_end_nonce) begin
          w_fin       = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_nonce_inc = 1'b1;
          w_state_nxt = S_WR_BLK;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if ((r_state != S_IDLE) && sha_error) begin
      w_err_set   = 1'b1;
      w_fin       = 1'b1;
      w_hit       = 1'b0;
      w_nonce_inc = 1'b0;
      w_blk1_go   = 1'b0;
      w_state_nxt = S_IDLE;
    end

    if (abort) begin
      w_start_ok  = 1'b0;
      w_fin       = 1'b0;
      w_err_set   = 1'b0;
      w_hit       = 1'b0;
      w_nonce_inc = 1'b0;
      w_blk1_go   = 1'b0;
      w_state_nxt = S_IDLE;
    end
  end

  // Header store: writable only while idle, out-of-range indices dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 19; i++) r_hdr[i] <= '0;
    end else if ((r_state == S_IDLE) && hdr_we && (hdr_addr <= 5'd18)) begin
      r_hdr[hdr_addr] <= hdr_wdata;
    end
  end

  // Sweep datapath: counters, nonce, digest capture and sticky result flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_word        <= '0;
      r_blk         <= 1'b0;
      r_poll_cnt    <= '0;
      r_cur_nonce   <= '0;
      r_end_nonce   <= '0;
      r_tz          <= '0;
      r_hash_w0     <= '0;
      r_found_nonce <= '0;
      r_found       <= 1'b0;
      r_err         <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= w_fin;
      if (r_state == S_POLL) r_poll_cnt <= r_poll_cnt + PW'(1);
      else                   r_poll_cnt <= '0;
      if (r_state == S_WR_BLK) r_word <= r_word + 4'd1;
      if (r_state == S_RD_DIG) r_hash_w0 <= sha_read_data;
      if (w_blk1_go) r_blk <= 1'b1;
      if (w_nonce_inc) begin
        r_cur_nonce <= r_cur_nonce + 32'd1;
        r_blk       <= 1'b0;
      end
      if (w_err_set) r_err <= 1'b1;
      if (w_hit) begin
        r_found       <= 1'b1;
        r_found_nonce <= r_cur_nonce;
      end
      if (w_start_ok) begin
        r_cur_nonce <= nonce_start;
        r_end_nonce <= nonce_end;
        r_tz        <= (target_zeros > 6'd32) ? 6'd32 : target_zeros;
        r_found     <= 1'b0;
        r_err       <= 1'b0;
        r_word      <= '0;
        r_blk       <= 1'b0;
      end
    end
  end

`ifdef SHA_SWEEP_IRQ_EN
  logic r_irq;

  // Hit interrupt pulse, aligned with the done pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_irq <= 1'b0;
    else          r_irq <= w_hit && !irq_mask;
  end

  assign irq_found = r_irq;
`endif

  assign busy           = (r_state != S_IDLE);
  assign done           = r_done;
  assign found          = r_found;
  assign err            = r_err;
  assign found_nonce    = r_found_nonce;
  assign cur_nonce      = r_cur_nonce;
  assign hash_w0        = r_hash_w0;
  assign sha_cs         = w_cs;
  assign sha_we         = w_we;
  assign sha_address    = w_addr;
  assign sha_write_data = w_wdata;

endmodule
`default_nettype wire

// File: tb/tb_sha_nonce_sweep_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sha_nonce_sweep_ctrl
// Description : Self-checking bench for sha_nonce_sweep_ctrl. A register-level
//               core stand-in folds the two written blocks into a toy digest;
//               a reference model computes the same digest straight from the
//               padded 80-byte message to predict each sweep's outcome.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha_nonce_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        hdr_we = 1'b0;
  logic [4:0]  hdr_addr = '0;
  logic [31:0] hdr_wdata = '0;
  logic [31:0] nonce_start = '0;
  logic [31:0] nonce_end = '0;
  logic [5:0]  target_zeros = '0;
  logic        busy, done, found, err;
  logic [31:0] found_nonce, cur_nonce, hash_w0;
  logic        sha_cs, sha_we;
  logic [7:0]  sha_address;
  logic [31:0] sha_write_data, sha_read_data;
  logic        sha_error = 1'b0;
`ifdef SHA_SWEEP_IRQ_EN
  logic        irq_found;
`endif

  sha_nonce_sweep_ctrl #(.BITS(32), .POLL_MAX(255)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .hdr_we(hdr_we), .hdr_addr(hdr_addr), .hdr_wdata(hdr_wdata),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .target_zeros(target_zeros),
    .busy(busy), .done(done), .found(found), .err(err),
    .found_nonce(found_nonce), .cur_nonce(cur_nonce), .hash_w0(hash_w0),
    .sha_cs(sha_cs), .sha_we(sha_we), .sha_address(sha_address),
    .sha_write_data(sha_write_data), .sha_read_data(sha_read_data),
    .sha_error(sha_error)
`ifdef SHA_SWEEP_IRQ_EN
    ,.irq_found(irq_found), .irq_mask(1'b0)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [31:0] IV = 32'h6a09_e667;

  function automatic logic [31:0] mix(input logic [31:0] h, input logic [31:0] w);
    logic [31:0] t;
    t = h ^ w;
    return (t * 32'h0100_0193) ^ (t >> 15);
  endfunction

  function automatic logic [31:0] fold_blk(input logic [31:0] h, input logic [31:0] b [16]);
    logic [31:0] r;
    r = h;
    for (int i = 0; i < 16; i++) r = mix(r, b[i]);
    return r;
  endfunction

  // ---------------- core stand-in ----------------
  logic [31:0] s_buf [16];
  logic [31:0] blk0_cap [16];
  logic [31:0] blk1_cap [16];
  logic [31:0] s_st = '0;
  int          s_cnt = 0;
  int          stub_lat = 1;
  bit          stub_hang = 1'b0;
  int          n_init, n_next, n_polls, n_bad_ctrl;
  logic [31:0] seen_q [$];
  logic        s_ready;

  assign s_ready = (s_cnt == 0) && !stub_hang;
  assign sha_read_data = (sha_cs && !sha_we && sha_address == 8'h09) ? {30'd0, s_ready, s_ready} :
                         (sha_cs && !sha_we && sha_address == 8'h20) ? s_st : 32'd0;

  always @(posedge clk) begin
    if (sha_cs && sha_we) begin
      if (sha_address[7:4] == 4'h1) begin
        s_buf[sha_address[3:0]] <= sha_write_data;
      end else if (sha_address == 8'h08) begin
        if (sha_write_data == 32'h5) begin
          s_st <= fold_blk(IV, s_buf);
          blk0_cap <= s_buf;
          n_init++;
        end else if (sha_write_data == 32'h6) begin
          s_st <= fold_blk(s_st, s_buf);
          blk1_cap <= s_buf;
          n_next++;
          seen_q.push_back(s_buf[3]);
        end else begin
          n_bad_ctrl++;
        end
        s_cnt <= stub_lat;
      end
    end else if (s_cnt != 0) begin
      s_cnt <= s_cnt - 1;
    end
    if (sha_cs && !sha_we && sha_address == 8'h09) n_polls++;
  end

  // ---------------- reference model ----------------
  logic [31:0] hdr_m [19];
  logic [31:0] exp_q [$];

  function automatic logic [31:0] model_digest(input logic [31:0] n);
    logic [31:0] msg [32];
    logic [31:0] h;
    for (int i = 0; i < 19; i++) msg[i] = hdr_m[i];
    msg[19] = n;
    msg[20] = 32'h8000_0000;
    for (int i = 21; i < 31; i++) msg[i] = 32'h0;
    msg[31] = 32'd640;
    h = IV;
    for (int i = 0; i < 32; i++) h = mix(h, msg[i]);
    return h;
  endfunction

  function automatic bit model_hit(input logic [31:0] d, input logic [5:0] tz);
    int t;
    t = (tz > 6'd32) ? 32 : int'(tz);
    if (t == 0) return 1'b1;
    return (d >> (32 - t)) == 32'd0;
  endfunction

  task automatic model_sweep(input logic [31:0] ns, input logic [31:0] ne, input logic [5:0] tz,
                             output bit f, output logic [31:0] fn, output logic [31:0] cur,
                             output logic [31:0] last, output int cnt);
    logic [31:0] n;
    n = ns; f = 1'b0; fn = '0; cnt = 0; cur = ns; last = '0;
    exp_q.delete();
    while (cnt < 1000) begin
      last = model_digest(n);
      cur = n;
      cnt++;
      exp_q.push_back(n);
      if (model_hit(last, tz)) begin
        f = 1'b1; fn = n; break;
      end
      if (n == ne) break;
      n = n + 32'd1;
    end
  endtask

  // ---------------- checking helpers ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_hdr(input bit rnd);
    for (int i = 0; i < 19; i++) begin
      hdr_m[i] = rnd ? $urandom : 32'(i);
      hdr_we = 1'b1; hdr_addr = 5'(i); hdr_wdata = hdr_m[i];
      tick();
    end
    hdr_we = 1'b0;
  endtask

  task automatic clear_stub();
    n_init = 0; n_next = 0; n_polls = 0; n_bad_ctrl = 0;
    seen_q.delete();
  endtask

  task automatic kick(input logic [31:0] ns, input logic [31:0] ne, input logic [5:0] tz);
    clear_stub();
    nonce_start = ns; nonce_end = ne; target_zeros = tz;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int cycles, output bit got);
    cycles = 0; got = 1'b0;
    while (cycles < bound && !got) begin
      tick();
      cycles++;
      if (done) got = 1'b1;
    end
  endtask

  // Full sweep against the model; disturb pokes header/start mid-sweep
  task automatic verify_sweep(input string nm, input logic [31:0] ns, input logic [31:0] ne,
                              input logic [5:0] tz, input bit disturb);
    bit f, got; logic [31:0] fn, cur, last; int cnt, cycles;
    model_sweep(ns, ne, tz, f, fn, cur, last, cnt);
    kick(ns, ne, tz);
    cycles = 0; got = 1'b0;
    if (disturb) begin
      repeat (8) tick();
      cycles = 8;
      hdr_we = 1'b1; hdr_addr = 5'd0; hdr_wdata = 32'hDEAD_BEEF;
      start = 1'b1; nonce_start = ns ^ 32'h5555_0000;
      tick();
      cycles++;
      hdr_we = 1'b0; start = 1'b0;
    end
    while (cycles < 20000 && !got) begin
      tick();
      cycles++;
      if (done) got = 1'b1;
    end
    chk({nm, " done"}, 64'(got), 64'd1);
    chk({nm, " latency"}, 64'(cycles), 64'(cnt * (2 * (18 + stub_lat) + 2)));
    chk({nm, " found"}, 64'(found), 64'(f));
    if (f) chk({nm, " found_nonce"}, 64'(found_nonce), 64'(fn));
    chk({nm, " cur_nonce"}, 64'(cur_nonce), 64'(cur));
    chk({nm, " hash_w0"}, 64'(hash_w0), 64'(last));
    chk({nm, " err"}, 64'(err), 64'd0);
    chk({nm, " init_cnt"}, 64'(n_init), 64'(cnt));
    chk({nm, " next_cnt"}, 64'(n_next), 64'(cnt));
    chk({nm, " poll_cnt"}, 64'(n_polls), 64'(2 * cnt * stub_lat));
    chk({nm, " bad_ctrl"}, 64'(n_bad_ctrl), 64'd0);
    chk({nm, " nonce_seq_len"}, 64'(seen_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++)
      chk({nm, " nonce_seq"}, 64'(seen_q[i]), 64'(exp_q[i]));
    tick();
    chk({nm, " done_single"}, 64'(done), 64'd0);
    chk({nm, " busy_after"}, 64'(busy), 64'd0);
  endtask

  typedef struct {
    logic [31:0] ns;
    logic [31:0] ne;
    logic [5:0]  tz;
    int          lat;
    bit          exp_found;
    logic [31:0] exp_cur;
    int          exp_cnt;
  } vec_t;

  vec_t tbl [5];

  initial begin
    bit got;
    int cycles;
    logic [31:0] ns, orv;
    int span;

    tbl[0] = '{ns: 32'h10,        ne: 32'h10,        tz: 6'd0,  lat: 1, exp_found: 1'b1, exp_cur: 32'h10,  exp_cnt: 1};
    tbl[1] = '{ns: 32'h0,         ne: 32'h4,         tz: 6'd32, lat: 2, exp_found: 1'b0, exp_cur: 32'h4,   exp_cnt: 5};
    tbl[2] = '{ns: 32'hFFFF_FFFE, ne: 32'h1,         tz: 6'd32, lat: 3, exp_found: 1'b0, exp_cur: 32'h1,   exp_cnt: 4};
    tbl[3] = '{ns: 32'h100,       ne: 32'h102,       tz: 6'd0,  lat: 1, exp_found: 1'b1, exp_cur: 32'h100, exp_cnt: 1};
    tbl[4] = '{ns: 32'h20,        ne: 32'h21,        tz: 6'd40, lat: 2, exp_found: 1'b0, exp_cur: 32'h21,  exp_cnt: 2};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst flags", {60'd0, done, found, err, sha_cs}, 64'd0);
    chk("rst nonces", {cur_nonce, found_nonce}, 64'd0);
    chk("rst hash_w0", 64'(hash_w0), 64'd0);
    chk("rst bus", {23'd0, sha_we, sha_address, sha_write_data}, 64'd0);
    reset_n = 1'b1;
    tick();

    // Directed table
    load_hdr(1'b0);
    for (int i = 0; i < 5; i++) begin
      stub_lat = tbl[i].lat;
      verify_sweep($sformatf("tbl%0d", i), tbl[i].ns, tbl[i].ne, tbl[i].tz, 1'b0);
      chk($sformatf("tbl%0d const_found", i), 64'(found), 64'(tbl[i].exp_found));
      chk($sformatf("tbl%0d const_cur", i), 64'(cur_nonce), 64'(tbl[i].exp_cur));
      chk($sformatf("tbl%0d const_cnt", i), 64'(n_next), 64'(tbl[i].exp_cnt));
      if (tbl[i].exp_found) chk($sformatf("tbl%0d const_fn", i), 64'(found_nonce), 64'(tbl[i].ns));
      if (i == 0) begin
        chk("bus 0x13", 64'(blk1_cap[3]), 64'h10);
        chk("bus 0x14", 64'(blk1_cap[4]), 64'h8000_0000);
        chk("bus 0x1F", 64'(blk1_cap[15]), 64'h280);
        chk("bus blk1 hdr16", 64'(blk1_cap[0]), 64'd16);
        for (int k = 0; k < 16; k++) chk("bus blk0 word", 64'(blk0_cap[k]), 64'(k));
      end
    end

    // Header write and start while busy are both ignored
    stub_lat = 2;
    verify_sweep("busy_ignore", 32'h40, 32'h42, 6'd32, 1'b1);
    chk("busy_ignore hdr0", 64'(blk0_cap[0]), 64'd0);

    // Abort during the third poll cycle
    stub_lat = 20;
    kick(32'h55, 32'h60, 6'd32);
    cycles = 0;
    while (cycles < 200 && n_polls != 2) begin
      tick();
      cycles++;
    end
    chk("abort reached poll3", 64'(sha_address), 64'h09);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort cs", 64'(sha_cs), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort cur_nonce kept", 64'(cur_nonce), 64'h55);
    tick();
    chk("abort no late done", 64'(done), 64'd0);
    stub_lat = 2;
    verify_sweep("after_abort", 32'h77, 32'h78, 6'd0, 1'b0);

    // Poll timeout
    stub_hang = 1'b1;
    kick(32'h9, 32'h9, 6'd0);
    wait_done(2000, cycles, got);
    stub_hang = 1'b0;
    chk("timeout done", 64'(got), 64'd1);
    chk("timeout polls", 64'(n_polls), 64'd255);
    chk("timeout err", 64'(err), 64'd1);
    chk("timeout found", 64'(found), 64'd0);
    chk("timeout busy", 64'(busy), 64'd0);

    // Core error mid WR_BLK
    stub_lat = 1;
    kick(32'hA, 32'hA, 6'd0);
    repeat (4) tick();
    sha_error = 1'b1;
    tick();
    sha_error = 1'b0;
    chk("sha_error err", 64'(err), 64'd1);
    chk("sha_error done", 64'(done), 64'd1);
    chk("sha_error busy", 64'(busy), 64'd0);

    // Asynchronous reset mid WR_BLK wipes everything, header included
    verify_sweep("pre_reset", 32'h77, 32'h77, 6'd0, 1'b0);
    kick(32'h88, 32'h90, 6'd0);
    repeat (5) tick();
    #3;
    reset_n = 1'b0;
    #1;
    chk("areset busy", 64'(busy), 64'd0);
    chk("areset flags", {60'd0, done, found, err, sha_cs}, 64'd0);
    chk("areset nonces", {cur_nonce, found_nonce}, 64'd0);
    chk("areset bus", {23'd0, sha_we, sha_address, sha_write_data}, 64'd0);
    chk("areset hash_w0", 64'(hash_w0), 64'd0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 19; i++) hdr_m[i] = 32'd0;
    tick();
    verify_sweep("post_reset", 32'h33, 32'h33, 6'd0, 1'b0);
    orv = 32'd0;
    for (int k = 0; k < 16; k++) orv = orv | blk0_cap[k];
    chk("post_reset blk0 zero", 64'(orv), 64'd0);

    // Randomized sweeps against the model
    for (int it = 0; it < 10; it++) begin
      load_hdr(1'b1);
      stub_lat = $urandom_range(1, 4);
      span = $urandom_range(0, 4);
      ns = (it % 2 == 1) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3))) : $urandom;
      verify_sweep($sformatf("rnd%0d", it), ns, ns + 32'(span), 6'($urandom_range(0, 7)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sha_nonce_sweep_ctrl.md
Name: sha_nonce_sweep_ctrl

Overview:
- Autonomous nonce-sweep sequencer that owns the sha256 core's register bus (cs/we/address/write_data/read_data).
- Hashes an 80-byte header held in a local 19-word store plus a swept nonce, as two 512-bit SHA-256 blocks (init, then next).
- Compares digest word 0 against a leading-zero target and stops on a hit or at the end of the range.
- Sits between miner firmware/LA control and the sha256 instance, replacing per-word manual driving.

Parameters:
- BITS, 32, register data width; must be 32.
- POLL_MAX, 255, maximum status polls per block before the error abort.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a sweep from IDLE
- abort  in  1  level; forces return to IDLE
- hdr_we  in  1  header store write strobe
- hdr_addr  in  5  header word index, 0..18
- hdr_wdata  in  32  header word
- nonce_start  in  32  first nonce; sampled on start
- nonce_end  in  32  last nonce, inclusive; sampled on start
- target_zeros  in  6  leading zero bits required in digest word 0, 0..32; sampled on start
- busy  out  1  high outside IDLE
- done  out  1  single-cycle pulse when a sweep ends
- found  out  1  sticky hit flag; cleared on start
- err  out  1  sticky poll-timeout / core-error flag; cleared on start
- found_nonce  out  32  nonce of the hit
- cur_nonce  out  32  nonce being hashed
- hash_w0  out  32  last digest word 0 read
- sha_cs  out  1  core chip select
- sha_we  out  1  core write enable
- sha_address  out  8  core register address
- sha_write_data  out  32  core write data
- sha_read_data  in  32  core read data; combinational for the current address
- sha_error  in  1  core error output

Behaviour:
- Reset values: all outputs 0, state IDLE, header store zeroed.
- Header store: hdr_we writes are accepted only in IDLE. Writes with hdr_addr > 18 are dropped. Writes while busy are ignored.
- start: honoured only in IDLE. Latches nonce_start into cur_nonce, latches nonce_end and target_zeros, clears found/err, enters WR_BLK with blk=0. start while busy is ignored.
- WR_BLK: one write per cycle, cs=1, we=1, addresses 0x10..0x1F, 16 cycles.
  - blk=0 data: header words 0..15.
  - blk=1 data: header words 16, 17, 18, cur_nonce, 0x80000000, ten words of 0x00000000, 0x00000280.
- WR_CTRL: one cycle writing address 0x08.
  - blk=0 data: 0x00000005 (init, mode 256).
  - blk=1 data: 0x00000006 (next, mode 256).
- GAP: one cycle with cs=0, so the core's ready bit drops before polling.
- POLL: cs=1, we=0, address 0x09 each cycle. Exit when read_data[0]=1 and read_data[1]=1.
  - blk=0 exit goes to WR_BLK with blk=1.
  - blk=1 exit goes to RD_DIG.
  - Exceeding POLL_MAX polls, or sha_error=1 in any state, sets err, pulses done, and returns to IDLE.
- RD_DIG: one cycle reading address 0x20; read_data is captured into hash_w0.
- CHECK: hit when the top target_zeros bits of hash_w0 are all 0; target_zeros=0 always hits, values above 32 are clamped to 32.
  - On hit: found=1, found_nonce=cur_nonce, done pulse, go to IDLE.
  - Else if cur_nonce==nonce_end: done pulse (found=0), go to IDLE.
  - Else: cur_nonce+1 (modulo 2^32), go to WR_BLK with blk=0.
- Wrap-around: nonce_end < nonce_start sweeps through 0xFFFFFFFF to 0. nonce_end == nonce_start hashes exactly one nonce.
- abort: takes priority over every transition. Next state is IDLE with cs=we=0, no done pulse; found/err/cur_nonce keep their values. abort together with start in IDLE: abort wins.
- IDLE drives cs=we=0, address 0x00, write_data 0.
- Latency per nonce: 2×(16+1+1+polls) + 2 cycles.
- reset_n low mid-sweep: everything returns immediately to its reset value; header contents are lost.

Optional Feature:
- Macro: SHA_SWEEP_IRQ_EN.
  - Defined: adds output irq_found (1 bit), a one-cycle pulse coincident with done when the hit case fires. Adds input irq_mask (1 bit); irq_mask=1 suppresses the pulse.
  - Undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Load header words 0..18 = index value. Start with nonce_start=0x10, nonce_end=0x10, target_zeros=0 -> found=1, found_nonce=0x10, one done pulse, and bus writes 0x13=0x00000010, 0x14=0x80000000, 0x1F=0x00000280.
- target_zeros=32, nonce 0x0..0x4 (behavioral sha256 model) -> exactly 5 block-1 ctrl writes of 0x6, done pulse, found=0 unless a digest word 0 is 0, cur_nonce=0x4.
- nonce_start=0xFFFFFFFE, nonce_end=0x00000001, target_zeros=32 -> nonces 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 appear at address 0x13, then done.
- abort asserted during the third POLL cycle -> next cycle busy=0, cs=0, no done pulse; a subsequent start runs normally.
- Core stub holding status=0 -> after 255 polls err=1, done pulse, IDLE. Stub asserting sha_error mid-WR_BLK -> err=1 next cycle.
- reset_n pulled low mid-WR_BLK -> all outputs 0 asynchronously; after release, header reads as zeros (block-0 writes all 0).
